// File: rtl/spi_mode1_slave.sv
// ----------------------------------------------------------------------------
// spi_mode1_slave
//   SPI mode-1 (CPOL=0, CPHA=1) peripheral for the master/LED link.
//   sclk/cs_n/mosi are oversampled on i_clk through SYNC_STAGES-deep
//   synchronizers. One LSB-first byte is received per chip-select frame.
//   Each received byte drives one of two LED banks: bit0 selects the bank
//   (0 = red, 1 = blue) and bits[DATA_WIDTH-1:1] become that bank's pattern.
//   A byte queued through the tx handshake is returned on miso in the next
//   frame. If nothing is queued, 0x00 is returned and o_tx_underrun pulses.
//
// Ports
//   i_clk          system clock, at least 4x sclk
//   i_rst          synchronous reset, active-low
//   i_sclk         SPI clock from the master, idles low
//   i_cs_n         chip select, active-low
//   i_mosi         serial data from the master, LSB first
//   o_miso         serial data to the master, LSB first (0 while not driven)
//   o_miso_oe      miso drive enable
//   i_tx_data      byte to return in the next frame
//   i_tx_valid     i_tx_data offered
//   o_tx_ready     one-entry tx buffer is empty
//   o_rx_data      last complete received byte
//   o_rx_valid     1-clk pulse when o_rx_data is updated
//   o_tx_underrun  1-clk pulse: frame started with the tx buffer empty
//   o_frame_err    1-clk pulse: cs_n rose before a full byte arrived
//   o_led_red      red LED pattern
//   o_led_blue     blue LED pattern
//
// State table
//   state    | meaning
//   WAIT_HI  | after reset; waits for cs_n high so a half frame is never armed
//   IDLE     | deselected; a cs_n fall loads the tx shifter and starts a frame
//   ACTIVE   | shifting: miso on sclk rise, mosi sampled on sclk fall
//   DONE     | full byte taken; further sclk edges ignored until cs_n rises
// ----------------------------------------------------------------------------
module spi_mode1_slave #(
   parameter int DATA_WIDTH  = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_sclk,
   input  logic                  i_cs_n,
   input  logic                  i_mosi,
   output logic                  o_miso,
   output logic                  o_miso_oe,
   input  logic [DATA_WIDTH-1:0] i_tx_data,
   input  logic                  i_tx_valid,
   output logic                  o_tx_ready,
   output logic [DATA_WIDTH-1:0] o_rx_data,
   output logic                  o_rx_valid,
   output logic                  o_tx_underrun,
   output logic                  o_frame_err,
   output logic [DATA_WIDTH-2:0] o_led_red,
   output logic [DATA_WIDTH-2:0] o_led_blue
);

   localparam int CNT_W = $clog2(DATA_WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

   typedef enum logic [1:0] {
      S_WAIT_HI = 2'd0,
      S_IDLE    = 2'd1,
      S_ACTIVE  = 2'd2,
      S_DONE    = 2'd3
   } state_t;

   state_t r_state;

   // -------------------------------------------------------------------------
   // Input synchronizers and edge detection
   // -------------------------------------------------------------------------
   // The cs_n chain resets to 0 rather than 1. If it reset to 1, a master
   // still holding cs_n low would flush a 1->0 transition through the chain
   // after reset and look like a fresh frame start. WAIT_HI therefore only
   // leaves once a real high level has come through from the pin.
   logic [SYNC_STAGES-1:0] r_sclk_sync;
   logic [SYNC_STAGES-1:0] r_cs_n_sync;
   logic [SYNC_STAGES-1:0] r_mosi_sync;
   logic                   r_sclk_d;
   logic                   r_cs_n_d;

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_sclk_sync <= '0;
         r_cs_n_sync <= '0;
         r_mosi_sync <= '0;
         r_sclk_d    <= 1'b0;
         r_cs_n_d    <= 1'b0;
      end else begin
         r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_sclk};
         r_cs_n_sync <= {r_cs_n_sync[SYNC_STAGES-2:0], i_cs_n};
         r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_mosi};
         r_sclk_d    <= r_sclk_sync[SYNC_STAGES-1];
         r_cs_n_d    <= r_cs_n_sync[SYNC_STAGES-1];
      end
   end

   logic w_sclk_s;
   logic w_cs_n_s;
   logic w_mosi_s;
   logic w_sclk_rise;
   logic w_sclk_fall;
   logic w_cs_rise;
   logic w_cs_fall;

   assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
   assign w_cs_n_s    = r_cs_n_sync[SYNC_STAGES-1];
   assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
   assign w_sclk_rise =  w_sclk_s & ~r_sclk_d;
   assign w_sclk_fall = ~w_sclk_s &  r_sclk_d;
   assign w_cs_rise   =  w_cs_n_s & ~r_cs_n_d;
   assign w_cs_fall   = ~w_cs_n_s &  r_cs_n_d;

   // -------------------------------------------------------------------------
   // One-entry tx buffer
   // -------------------------------------------------------------------------
   logic [DATA_WIDTH-1:0] r_tx_buf;
   logic                  r_tx_full;
   logic                  w_frame_start;

   assign w_frame_start = (r_state == S_IDLE) && w_cs_fall;

   // A capture only happens while the buffer is empty, so it can never
   // collide with a frame start that consumes a full buffer. A capture in
   // the same clk as an underrun frame start is held for the next frame.
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_tx_buf  <= '0;
         r_tx_full <= 1'b0;
      end else begin
         if (w_frame_start && r_tx_full) begin
            r_tx_full <= 1'b0;
         end
         if (i_tx_valid && !r_tx_full) begin
            r_tx_buf  <= i_tx_data;
            r_tx_full <= 1'b1;
         end
      end
   end

   assign o_tx_ready = ~r_tx_full;

   // -------------------------------------------------------------------------
   // Frame FSM with registered outputs
   // -------------------------------------------------------------------------
   logic [DATA_WIDTH-1:0] r_tx_sr;
   logic [DATA_WIDTH-1:0] r_rx_sr;
   logic [CNT_W-1:0]      r_bit_cnt;
   logic [DATA_WIDTH-1:0] w_rx_byte;

   // Byte as it stands once the current fall's mosi bit is shifted in.
   assign w_rx_byte = {w_mosi_s, r_rx_sr[DATA_WIDTH-1:1]};

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_state       <= S_WAIT_HI;
         r_tx_sr       <= '0;
         r_rx_sr       <= '0;
         r_bit_cnt     <= '0;
         o_miso        <= 1'b0;
         o_miso_oe     <= 1'b0;
         o_rx_data     <= '0;
         o_rx_valid    <= 1'b0;
         o_tx_underrun <= 1'b0;
         o_frame_err   <= 1'b0;
         o_led_red     <= '0;
         o_led_blue    <= '0;
      end else begin
         o_rx_valid    <= 1'b0;
         o_tx_underrun <= 1'b0;
         o_frame_err   <= 1'b0;
         // Not driven while waiting out a frame that was cut by reset.
         o_miso_oe     <= ~w_cs_n_s && (r_state != S_WAIT_HI);

         case (r_state)
            S_WAIT_HI: begin
               o_miso <= 1'b0;
               if (w_cs_n_s) begin
                  r_state <= S_IDLE;
               end
            end

            S_IDLE: begin
               o_miso <= 1'b0;
               if (w_cs_fall) begin
                  r_state       <= S_ACTIVE;
                  r_bit_cnt     <= '0;
                  r_rx_sr       <= '0;
                  r_tx_sr       <= r_tx_full ? r_tx_buf : '0;
                  o_tx_underrun <= ~r_tx_full;
               end
            end

            S_ACTIVE: begin
               // cs_n rise has priority over a coincident sclk edge.
               if (w_cs_rise) begin
                  o_frame_err <= 1'b1;
                  o_miso      <= 1'b0;
                  r_state     <= S_IDLE;
               end else if (w_sclk_rise) begin
                  o_miso  <= r_tx_sr[0];
                  r_tx_sr <= r_tx_sr >> 1;
               end else if (w_sclk_fall) begin
                  r_rx_sr   <= w_rx_byte;
                  r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                  if (r_bit_cnt == LAST_BIT) begin
                     o_rx_data  <= w_rx_byte;
                     o_rx_valid <= 1'b1;
                     if (w_rx_byte[0]) begin
                        o_led_blue <= w_rx_byte[DATA_WIDTH-1:1];
                     end else begin
                        o_led_red  <= w_rx_byte[DATA_WIDTH-1:1];
                     end
                     r_state <= S_DONE;
                  end
               end
            end

            S_DONE: begin
               if (w_cs_rise) begin
                  o_miso  <= 1'b0;
                  r_state <= S_IDLE;
               end
            end

            default: begin
               r_state <= S_WAIT_HI;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spi_mode1_slave.sv
// ----------------------------------------------------------------------------
// tb_spi_mode1_slave
//   Directed bench for spi_mode1_slave. The master is modelled with slow sclk
//   (8 clk per half period) so the synchronizer latency is well hidden.
//   Inputs are driven and outputs sampled on the falling clk edge.
// ----------------------------------------------------------------------------
module tb_spi_mode1_slave;

   localparam int HALF = 8;

   logic       clk = 1'b0;
   logic       rst;
   logic       sclk;
   logic       cs_n;
   logic       mosi;
   logic       miso;
   logic       miso_oe;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       tx_underrun;
   logic       frame_err;
   logic [6:0] led_red;
   logic [6:0] led_blue;

   int n_vec = 0;
   int n_err = 0;

   int cnt_rxv = 0;
   int cnt_und = 0;
   int cnt_ferr = 0;

   always #5 clk = ~clk;

   spi_mode1_slave #(
      .DATA_WIDTH  (8),
      .SYNC_STAGES (2)
   ) u_dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_sclk        (sclk),
      .i_cs_n        (cs_n),
      .i_mosi        (mosi),
      .o_miso        (miso),
      .o_miso_oe     (miso_oe),
      .i_tx_data     (tx_data),
      .i_tx_valid    (tx_valid),
      .o_tx_ready    (tx_ready),
      .o_rx_data     (rx_data),
      .o_rx_valid    (rx_valid),
      .o_tx_underrun (tx_underrun),
      .o_frame_err   (frame_err),
      .o_led_red     (led_red),
      .o_led_blue    (led_blue)
   );

   always @(negedge clk) begin
      if (rx_valid)    cnt_rxv  <= cnt_rxv + 1;
      if (tx_underrun) cnt_und  <= cnt_und + 1;
      if (frame_err)   cnt_ferr <= cnt_ferr + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic sbit(input logic b, output logic m);
      sclk = 1'b1;
      mosi = b;
      tick(HALF);
      m = miso;
      sclk = 1'b0;
      tick(HALF);
   endtask

   task automatic frame(input logic [7:0] b, input int nbits,
                        output logic [7:0] mb, output logic oe);
      logic m;
      mb = 8'h00;
      cs_n = 1'b0;
      tick(HALF);
      oe = miso_oe;
      for (int i = 0; i < nbits; i++) begin
         sbit(b[i], m);
         mb[i] = m;
      end
      cs_n = 1'b1;
      tick(HALF);
   endtask

   logic [7:0] mb;
   logic       oe;
   logic       m;
   int         rxv0, und0, ferr0;
   logic [7:0] seq [16];

   initial begin
      seq = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h00,
              8'h03, 8'h05, 8'h09, 8'h11, 8'h21, 8'h41, 8'h81, 8'h01};
      rst = 1'b0; cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
      tx_valid = 1'b0; tx_data = 8'h00;
      tick(4);

      // reset state
      chk("rst_miso",     32'(miso), 0);
      chk("rst_oe",       32'(miso_oe), 0);
      chk("rst_tx_ready", 32'(tx_ready), 1);
      chk("rst_rx_data",  32'(rx_data), 0);
      chk("rst_led_red",  32'(led_red), 0);
      chk("rst_led_blue", 32'(led_blue), 0);
      rst = 1'b1;
      tick(8);

      // 1: frame 0x04 into the red bank, nothing queued
      rxv0 = cnt_rxv; und0 = cnt_und;
      frame(8'h04, 8, mb, oe);
      chk("t1_led_red",  32'(led_red), 32'h02);
      chk("t1_led_blue", 32'(led_blue), 0);
      chk("t1_rx_data",  32'(rx_data), 32'h04);
      chk("t1_rxv",      32'(cnt_rxv - rxv0), 1);
      chk("t1_oe",       32'(oe), 1);
      chk("t1_oe_after", 32'(miso_oe), 0);

      // 2: queued 0xA5 returned LSB first, frame 0x03 into the blue bank
      tx_data = 8'hA5; tx_valid = 1'b1;
      tick(1);
      tx_valid = 1'b0;
      tick(1);
      chk("t2_tx_ready_busy", 32'(tx_ready), 0);
      und0 = cnt_und;
      frame(8'h03, 8, mb, oe);
      chk("t2_miso",     32'(mb), 32'hA5);
      chk("t2_led_blue", 32'(led_blue), 32'h01);
      chk("t2_led_red",  32'(led_red), 32'h02);
      chk("t2_tx_ready", 32'(tx_ready), 1);
      chk("t2_no_und",   32'(cnt_und - und0), 0);

      // 3: underrun frame 0x80
      und0 = cnt_und;
      frame(8'h80, 8, mb, oe);
      chk("t3_und",     32'(cnt_und - und0), 1);
      chk("t3_miso",    32'(mb), 0);
      chk("t3_led_red", 32'(led_red), 32'h40);

      // 4: aborted after 5 bits, then a good frame
      rxv0 = cnt_rxv; ferr0 = cnt_ferr;
      frame(8'hFF, 5, mb, oe);
      tick(4);
      chk("t4_ferr",     32'(cnt_ferr - ferr0), 1);
      chk("t4_rxv",      32'(cnt_rxv - rxv0), 0);
      chk("t4_led_red",  32'(led_red), 32'h40);
      chk("t4_led_blue", 32'(led_blue), 32'h01);
      chk("t4_rx_data",  32'(rx_data), 32'h80);
      frame(8'h06, 8, mb, oe);
      chk("t4_next_red", 32'(led_red), 32'h03);
      chk("t4_next_rx",  32'(rx_data), 32'h06);

      // 5: reset after bit 3 with cs_n held low
      rxv0 = cnt_rxv; ferr0 = cnt_ferr;
      cs_n = 1'b0;
      tick(HALF);
      for (int i = 0; i < 3; i++) sbit(1'b1, m);
      rst = 1'b0;
      tick(4);
      rst = 1'b1;
      tick(2);
      chk("t5_rx_data",  32'(rx_data), 0);
      chk("t5_led_red",  32'(led_red), 0);
      chk("t5_led_blue", 32'(led_blue), 0);
      chk("t5_tx_ready", 32'(tx_ready), 1);
      for (int i = 0; i < 5; i++) sbit(1'b1, m);
      chk("t5_rxv",  32'(cnt_rxv - rxv0), 0);
      chk("t5_ferr", 32'(cnt_ferr - ferr0), 0);
      chk("t5_oe",   32'(miso_oe), 0);
      chk("t5_miso", 32'(miso), 0);
      cs_n = 1'b1;
      tick(HALF);
      frame(8'h09, 8, mb, oe);
      chk("t5_next_blue", 32'(led_blue), 32'h04);
      chk("t5_next_rx",   32'(rx_data), 32'h09);
      chk("t5_next_red",  32'(led_red), 0);

      // 6: sixteen-byte walk over both banks
      rxv0 = cnt_rxv;
      for (int i = 0; i < 16; i++) frame(seq[i], 8, mb, oe);
      chk("t6_rxv",      32'(cnt_rxv - rxv0), 16);
      chk("t6_led_red",  32'(led_red), 0);
      chk("t6_led_blue", 32'(led_blue), 0);
      chk("t6_rx_data",  32'(rx_data), 32'h01);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
